// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and state encoding for the cache miss/fill engine.
package cache_fill_fsm_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_FILL = 1'b1
   } fill_state_t;

   localparam int unsigned WORDS_PER_BLOCK = 8;
   localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned BLK_OFF_W       = WORD_IDX_W + 1;
   localparam int unsigned FILL_CNT_W      = WORD_IDX_W + 1;
   localparam int unsigned MEM_LATENCY     = 4;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Resettable up-counter with synchronous clear, enable and terminal-count flag.
module fill_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LAST  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + WIDTH'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == WIDTH'(LAST));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches a full block word-by-word from pipelined memory
// and writes it into the cache data array, then the tag/valid entry.
module cache_fill_fsm #(
   parameter int unsigned ADDR_W          = 16,
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned WORDS_PER_BLOCK = cache_fill_fsm_pkg::WORDS_PER_BLOCK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              miss_detected,
   input  logic [ADDR_W-1:0] miss_address,
   input  logic [DATA_W-1:0] memory_data,
   input  logic              memory_data_valid,
   output logic              fsm_busy,
   output logic              mem_read,
   output logic [ADDR_W-1:0] memory_address,
   output logic              write_data_array,
   output logic              write_tag_array,
   output logic [ADDR_W-1:0] cache_wr_address,
   output logic [DATA_W-1:0] cache_wr_data
);

   import cache_fill_fsm_pkg::*;

   localparam int unsigned IDX_W = $clog2(WORDS_PER_BLOCK);
   localparam int unsigned CNT_W = IDX_W + 1;
   localparam int unsigned OFF_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   fill_state_t       r_state;
   logic [ADDR_W-1:0] r_base;

   logic [CNT_W-1:0]  w_req_cnt;
   logic [CNT_W-1:0]  w_resp_cnt;
   logic              w_req_done;
   logic              w_resp_tc;
   logic              w_fill;
   logic              w_start;
   logic              w_issue;
   logic              w_resp;
   logic              w_last_resp;
   logic [ADDR_W-1:0] w_req_addr;
   logic [ADDR_W-1:0] w_resp_addr;

   assign w_fill      = (r_state == ST_FILL);
   assign w_start     = (r_state == ST_IDLE) && miss_detected;
   assign w_issue     = w_fill && !w_req_done;
   assign w_resp      = w_fill && memory_data_valid;
   assign w_last_resp = w_resp && w_resp_tc;

   // base has its offset bits cleared, so OR-ing in the word offset never carries
   assign w_req_addr  = r_base | ADDR_W'({w_req_cnt, 1'b0});
   assign w_resp_addr = r_base | ADDR_W'({w_resp_cnt, 1'b0});

   fill_counter #(
      .WIDTH (CNT_W),
      .LAST  (WORDS_PER_BLOCK)
   ) u_req_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  (w_issue),
      .o_cnt (w_req_cnt),
      .o_tc  (w_req_done)
   );

   fill_counter #(
      .WIDTH (CNT_W),
      .LAST  (WORDS_PER_BLOCK - 1)
   ) u_resp_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  (w_resp),
      .o_cnt (w_resp_cnt),
      .o_tc  (w_resp_tc)
   );

   // A miss coinciding with the last response is ignored; IDLE re-samples it next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_base  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (miss_detected) begin
                  r_state <= ST_FILL;
                  r_base  <= miss_address & BASE_MASK;
               end
            end
            ST_FILL: begin
               if (w_last_resp) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fsm_busy         = w_fill;
   assign mem_read         = w_issue;
   assign memory_address   = w_issue ? w_req_addr : '0;
   assign write_data_array = w_resp;
   assign write_tag_array  = w_last_resp;
   assign cache_wr_address = w_resp ? w_resp_addr : '0;
   assign cache_wr_data    = w_resp ? memory_data : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm with a queued pipelined-memory model.
module tb_cache_fill_fsm;

   import cache_fill_fsm_pkg::*;

   localparam int unsigned WPB = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        miss_detected = 1'b0;
   logic [15:0] miss_address = '0;
   logic [15:0] memory_data = '0;
   logic        memory_data_valid = 1'b0;
   logic        fsm_busy;
   logic        mem_read;
   logic [15:0] memory_address;
   logic        write_data_array;
   logic        write_tag_array;
   logic [15:0] cache_wr_address;
   logic [15:0] cache_wr_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cache_fill_fsm #(
      .ADDR_W          (16),
      .DATA_W          (16),
      .WORDS_PER_BLOCK (WPB)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .miss_detected     (miss_detected),
      .miss_address      (miss_address),
      .memory_data       (memory_data),
      .memory_data_valid (memory_data_valid),
      .fsm_busy          (fsm_busy),
      .mem_read          (mem_read),
      .memory_address    (memory_address),
      .write_data_array  (write_data_array),
      .write_tag_array   (write_tag_array),
      .cache_wr_address  (cache_wr_address),
      .cache_wr_data     (cache_wr_data)
   );

   // One complete fill; the memory answers each request in order after lat cycles.
   // gap_mode: 0 = answer as soon as ready, 1 = only on even cycles, 2 = random gaps.
   task automatic run_fill(input logic [15:0] addr, input int lat, input int gap_mode,
                           input bit hold_miss, output int idle_cyc);
      logic [15:0] base;
      logic [15:0] exp_addr, exp_wr_addr, exp_wr_data;
      logic [15:0] q_data[$];
      int          q_rdy[$];
      int          n_resp;
      int          cyc;
      bit          done, can_go, exp_busy, exp_rd, exp_wr, exp_tag;
      base     = addr & 16'hFFF0;
      idle_cyc = -1;
      @(posedge clk); #1;
      miss_detected     = 1'b1;
      miss_address      = addr;
      memory_data_valid = 1'b0;
      @(posedge clk); #1;
      if (!hold_miss) begin
         miss_detected = 1'b0;
         miss_address  = 16'($urandom);
      end
      n_resp = 0;
      cyc    = 1;
      done   = 1'b0;
      while (!done) begin
         exp_busy = (n_resp < WPB);
         can_go   = (q_rdy.size() > 0) && (q_rdy[0] <= cyc);
         if (gap_mode == 1)      can_go = can_go && (cyc % 2 == 0);
         else if (gap_mode == 2) can_go = can_go && ($urandom_range(0, 1) == 1);
         memory_data_valid = can_go;
         memory_data       = can_go ? q_data[0] : 16'($urandom);
         exp_wr      = can_go && exp_busy;
         exp_tag     = exp_wr && (n_resp == WPB - 1);
         exp_wr_addr = exp_wr ? base + 16'(2 * n_resp) : 16'h0;
         exp_wr_data = exp_wr ? q_data[0] : 16'h0;
         exp_rd      = (cyc >= 1) && (cyc <= WPB);
         exp_addr    = exp_rd ? base + 16'(2 * (cyc - 1)) : 16'h0;
         @(negedge clk);
         n_checks += 7;
         if (fsm_busy !== exp_busy) begin
            n_errors++;
            $display("FAIL busy a=%h cyc=%0d got=%b exp=%b", addr, cyc, fsm_busy, exp_busy);
         end
         if (mem_read !== exp_rd) begin
            n_errors++;
            $display("FAIL mem_read a=%h cyc=%0d got=%b exp=%b", addr, cyc, mem_read, exp_rd);
         end
         if (memory_address !== exp_addr) begin
            n_errors++;
            $display("FAIL mem_addr a=%h cyc=%0d got=%h exp=%h", addr, cyc, memory_address, exp_addr);
         end
         if (write_data_array !== exp_wr) begin
            n_errors++;
            $display("FAIL wr_data_strobe a=%h cyc=%0d got=%b exp=%b", addr, cyc, write_data_array, exp_wr);
         end
         if (write_tag_array !== exp_tag) begin
            n_errors++;
            $display("FAIL wr_tag a=%h cyc=%0d got=%b exp=%b", addr, cyc, write_tag_array, exp_tag);
         end
         if (cache_wr_address !== exp_wr_addr) begin
            n_errors++;
            $display("FAIL wr_addr a=%h cyc=%0d got=%h exp=%h", addr, cyc, cache_wr_address, exp_wr_addr);
         end
         if (cache_wr_data !== exp_wr_data) begin
            n_errors++;
            $display("FAIL wr_data a=%h cyc=%0d got=%h exp=%h", addr, cyc, cache_wr_data, exp_wr_data);
         end
         if (exp_rd) begin
            q_data.push_back(16'($urandom));
            q_rdy.push_back(cyc + lat);
         end
         if (can_go) begin
            void'(q_data.pop_front());
            void'(q_rdy.pop_front());
            n_resp++;
         end
         if (!exp_busy) begin
            done     = 1'b1;
            idle_cyc = cyc;
         end else if (cyc > 300) begin
            n_checks++;
            n_errors++;
            $display("FAIL fill_timeout a=%h got=%0d responses exp=%0d", addr, n_resp, WPB);
            done = 1'b1;
         end
         @(posedge clk); #1;
         memory_data_valid = 1'b0;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({fsm_busy, mem_read, write_data_array, write_tag_array, memory_address,
           cache_wr_address, cache_wr_data} !== 52'h0) begin
         n_errors++;
         $display("FAIL reset_outputs got busy=%b rd=%b wd=%b wt=%b ma=%h wa=%h wd=%h exp=all zero",
                  fsm_busy, mem_read, write_data_array, write_tag_array,
                  memory_address, cache_wr_address, cache_wr_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_basic_fill();
      int idle;
      run_fill(16'h1236, MEM_LATENCY, 0, 1'b0, idle);
      n_checks++;
      if (idle !== 13) begin
         n_errors++;
         $display("FAIL basic_idle_cycle got=%0d exp=13", idle);
      end
   endtask

   task automatic test_miss_held();
      int idle;
      run_fill(16'h00FE, MEM_LATENCY, 0, 1'b1, idle);
      n_checks++;
      if (idle !== 13) begin
         n_errors++;
         $display("FAIL held_idle_cycle got=%0d exp=13", idle);
      end
      @(negedge clk);
      n_checks++;
      if (fsm_busy !== 1'b1) begin
         n_errors++;
         $display("FAIL held_reaccept busy got=%b exp=1", fsm_busy);
      end
      rst = 1'b1;
      miss_detected = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_variable_latency();
      int idle;
      run_fill(16'h4A52, 2, 1, 1'b0, idle);
      run_fill(16'h7F08, 3, 2, 1'b0, idle);
   endtask

   task automatic test_reset_mid_fill();
      int idle;
      @(posedge clk); #1;
      miss_detected = 1'b1;
      miss_address  = 16'h3456;
      @(posedge clk); #1;
      miss_detected = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         memory_data_valid = (c >= 5);
         memory_data       = 16'($urandom);
         @(posedge clk); #1;
      end
      memory_data_valid = 1'b1;
      memory_data       = 16'hCAFE;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if ({fsm_busy, mem_read, write_data_array, write_tag_array, memory_address,
           cache_wr_address, cache_wr_data} !== 52'h0) begin
         n_errors++;
         $display("FAIL midfill_reset got busy=%b rd=%b wd=%b wt=%b ma=%h wa=%h wd=%h exp=all zero",
                  fsm_busy, mem_read, write_data_array, write_tag_array,
                  memory_address, cache_wr_address, cache_wr_data);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         memory_data_valid = 1'b1;
         memory_data       = 16'($urandom);
         @(negedge clk);
         n_checks++;
         if ({fsm_busy, write_data_array, write_tag_array, cache_wr_data} !== 19'h0) begin
            n_errors++;
            $display("FAIL stale_valid got busy=%b wd=%b wt=%b data=%h exp=all zero",
                     fsm_busy, write_data_array, write_tag_array, cache_wr_data);
         end
         @(posedge clk); #1;
      end
      memory_data_valid = 1'b0;
      run_fill(16'hA000, MEM_LATENCY, 0, 1'b0, idle);
   endtask

   task automatic test_spurious_valid();
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         memory_data_valid = 1'b1;
         memory_data       = 16'hBEEF;
         @(negedge clk);
         n_checks++;
         if ({fsm_busy, write_data_array, write_tag_array, cache_wr_address, cache_wr_data} !== 35'h0) begin
            n_errors++;
            $display("FAIL spurious_valid got busy=%b wd=%b wt=%b wa=%h data=%h exp=all zero",
                     fsm_busy, write_data_array, write_tag_array, cache_wr_address, cache_wr_data);
         end
      end
      @(posedge clk); #1;
      memory_data_valid = 1'b0;
   endtask

   task automatic test_address_wrap();
      int idle;
      run_fill(16'hFFFA, MEM_LATENCY, 0, 1'b0, idle);
   endtask

   task automatic test_random_fills();
      int idle;
      for (int i = 0; i < 8; i++) begin
         run_fill(16'($urandom), $urandom_range(1, 6), $urandom_range(0, 2), 1'b0, idle);
      end
   endtask

   initial begin
      test_reset();
      test_basic_fill();
      test_miss_held();
      test_variable_latency();
      test_reset_mid_fill();
      test_spurious_valid();
      test_address_wrap();
      test_random_fills();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss handler and fill engine for the direct-mapped caches. It writes into the cache; the cache only reads and reports a miss.
- On a miss it fetches the whole block from main memory, one word per request, and writes each returned word into the cache data array. It writes the tag/valid entry when the last word arrives.
- Sits between the cache (I or D) and the multi-cycle pipelined main memory. It drives the cache's write-enable side while the pipeline is stalled on fsm_busy.

Parameters:
- ADDR_W, 16, address width (byte addresses).
- DATA_W, 16, word width.
- WORDS_PER_BLOCK, 8, words per cache block; power of two; block = WORDS_PER_BLOCK*2 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- miss_detected  in  1  cache miss indication (level); sampled only in IDLE.
- miss_address  in  ADDR_W  address that missed; captured with miss_detected.
- memory_data  in  DATA_W  read data returned by memory.
- memory_data_valid  in  1  memory_data valid this cycle; one pulse per issued request, in order.
- fsm_busy  out  1  fill in progress; pipeline stall.
- mem_read  out  1  memory read request this cycle.
- memory_address  out  ADDR_W  request address.
- write_data_array  out  1  cache data-array write strobe.
- write_tag_array  out  1  cache tag/valid write strobe.
- cache_wr_address  out  ADDR_W  address of the word being written to the cache.
- cache_wr_data  out  DATA_W  word being written (equals memory_data).

Behaviour:
- States: IDLE and FILL. Registers: state, base (block-aligned address), req_cnt and resp_cnt (each log2(WORDS_PER_BLOCK)+1 bits).
- Reset (async, any time, including mid-fill): state=IDLE, counters=0, base=0.
  - All outputs are 0 while in IDLE.
  - Memory responses still in flight after reset are ignored.
- IDLE -> FILL:
  - On a clock edge with miss_detected=1.
  - base <= miss_address with its low log2(WORDS_PER_BLOCK*2) bits cleared; counters <= 0.
- FILL, request side:
  - mem_read = (req_cnt < WORDS_PER_BLOCK).
  - memory_address = base + 2*req_cnt.
  - req_cnt increments each cycle that mem_read=1, so one request per cycle, back-to-back.
- FILL, response side (combinational from memory_data_valid):
  - write_data_array = memory_data_valid.
  - cache_wr_address = base + 2*resp_cnt; cache_wr_data = memory_data.
  - resp_cnt increments on each valid response.
- Completion:
  - When memory_data_valid=1 and resp_cnt==WORDS_PER_BLOCK-1, write_tag_array=1 in that same cycle, alongside the last data write.
  - state <= IDLE; fsm_busy falls on the next cycle.
- fsm_busy = (state==FILL).
- Outside the active strobes, address and data outputs are 0 (never X).
- Ignored inputs:
  - miss_detected while in FILL.
  - memory_data_valid while in IDLE.
  - Responses beyond WORDS_PER_BLOCK cannot occur and need not be handled.
- Simultaneous last response and a new miss_detected: the miss is not accepted that cycle. The block returns to IDLE first, and the cache re-evaluates the miss against the refreshed tag.
- Arithmetic: base + 2*cnt is computed within the block offset only, with no carry into the tag/index bits.
- Timing with 4-cycle memory latency, miss sampled at edge 0:
  - busy cycles 1..12.
  - requests cycles 1..8.
  - data writes cycles 5..12; tag write cycle 12.
  - IDLE at cycle 13.

Decomposition:
- Shared package holds: fill-state encoding (IDLE=1'b0, FILL=1'b1), WORDS_PER_BLOCK, the block-offset width constant, and the memory latency constant used by benches.
- One natural sub-module, fill_counter: a resettable up-counter with enable and terminal-count flag. It is instantiated twice, for req_cnt and resp_cnt.

Test Plan:
- Basic fill: rst pulse, then miss_address=16'h1236 for 1 cycle with 4-cycle memory model.
  - mem_read at addresses 0x1230..0x123E in cycles 1..8.
  - write_data_array cycles 5..12 with cache_wr_address 0x1230..0x123E and matching data.
  - write_tag_array only in cycle 12; fsm_busy=1 exactly cycles 1..12.
- Miss held high through the fill (0x00FE): exactly one fill, base 0x00F0, 8 requests. The miss held at cycle 12 is not re-accepted; it is re-accepted at edge 13 (new fill starts with busy in cycle 14).
- Variable latency: memory returns with gaps (valid on alternate cycles). resp_cnt advances only on valid; the tag write coincides with the 8th valid; no extra writes.
- Reset mid-fill: assert rst asynchronously after 3 responses.
  - All outputs 0 immediately; state IDLE.
  - Stale valids afterwards produce no write_data_array.
  - A new miss at 0xA000 fills cleanly from 0xA000.
- Spurious valid in IDLE: memory_data_valid=1 with data 0xBEEF and no miss -> write_data_array, write_tag_array and fsm_busy stay 0.
- Address wrap: miss at 0xFFFA -> requests 0xFFF0..0xFFFE, no carry or overflow into 0x0000.
